// File: rtl/equiv_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// equiv_sweep_ctrl
//
// Exhaustive truth-table equivalence sequencer. Walks every (sel, vec) point of
// a bank of expression / simplified-expression pairs. Each point is driven for
// one settle cycle (DRIVE) and compared on the edge leaving SAMPLE. The block
// accumulates a per-pair equivalence mask, a total mismatch count and the
// location of the first mismatch.
//
// Ports
//   clk            : rising-edge clock
//   reset          : synchronous active-high reset (priority over start/abort)
//   start          : begin a sweep (accepted only in IDLE, and only if abort=0)
//   abort          : cancel a running sweep; partial results are kept
//   sel            : index of the pair currently driven
//   vec            : input vector applied to the selected pair
//   s_orig         : selected original-expression output
//   s_simp         : selected simplified-expression output
//   busy           : high while a sweep is in progress
//   done           : one-cycle pulse on normal completion
//   equiv_mask     : bit e set when pair e matched on every vector
//   mismatch_cnt   : number of mismatching (sel, vec) points
//   fail_seen      : at least one mismatch recorded
//   first_fail_sel : sel of the first mismatch
//   first_fail_vec : vec of the first mismatch
// -----------------------------------------------------------------------------
module equiv_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int N_EXPR = 5,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel,
  output logic [N_IN-1:0]   vec,
  input  logic              s_orig,
  input  logic              s_simp,
  output logic              busy,
  output logic              done,
  output logic [N_EXPR-1:0] equiv_mask,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              fail_seen,
  output logic [SEL_W-1:0]  first_fail_sel,
  output logic [N_IN-1:0]   first_fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_EXPR - 1);

  state_t state_r;
  state_t state_nxt_s;

  // Set while the current pair has mismatched on an earlier vector.
  logic pair_fail_r;
  logic pair_fail_nxt_s;

  logic [SEL_W-1:0]  sel_nxt_s;
  logic [N_IN-1:0]   vec_nxt_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic [N_EXPR-1:0] equiv_mask_nxt_s;
  logic [CNT_W-1:0]  mismatch_cnt_nxt_s;
  logic              fail_seen_nxt_s;
  logic [SEL_W-1:0]  first_fail_sel_nxt_s;
  logic [N_IN-1:0]   first_fail_vec_nxt_s;

  // 4-state compare: an X or Z on either bank output counts as a mismatch.
  logic mismatch_s;
  logic pair_bad_s;

  // Mismatch detection for the point currently held on sel/vec.
  always_comb begin
    mismatch_s = (s_orig !== s_simp);
    pair_bad_s = pair_fail_r | mismatch_s;
  end

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_nxt_s          = state_r;
    pair_fail_nxt_s      = pair_fail_r;
    sel_nxt_s            = sel;
    vec_nxt_s            = vec;
    busy_nxt_s           = busy;
    done_nxt_s           = 1'b0;
    equiv_mask_nxt_s     = equiv_mask;
    mismatch_cnt_nxt_s   = mismatch_cnt;
    fail_seen_nxt_s      = fail_seen;
    first_fail_sel_nxt_s = first_fail_sel;
    first_fail_vec_nxt_s = first_fail_vec;

    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt_s          = ST_DRIVE;
          pair_fail_nxt_s      = 1'b0;
          sel_nxt_s            = {SEL_W{1'b0}};
          vec_nxt_s            = {N_IN{1'b0}};
          busy_nxt_s           = 1'b1;
          equiv_mask_nxt_s     = {N_EXPR{1'b0}};
          mismatch_cnt_nxt_s   = {CNT_W{1'b0}};
          fail_seen_nxt_s      = 1'b0;
          first_fail_sel_nxt_s = {SEL_W{1'b0}};
          first_fail_vec_nxt_s = {N_IN{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          sel_nxt_s   = {SEL_W{1'b0}};
          vec_nxt_s   = {N_IN{1'b0}};
        end else begin
          state_nxt_s = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // The compare on this edge is dropped; partial results hold.
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          sel_nxt_s   = {SEL_W{1'b0}};
          vec_nxt_s   = {N_IN{1'b0}};
        end else begin
          if (mismatch_s) begin
            mismatch_cnt_nxt_s = mismatch_cnt + CNT_W'(1);
            if (!fail_seen) begin
              fail_seen_nxt_s      = 1'b1;
              first_fail_sel_nxt_s = sel;
              first_fail_vec_nxt_s = vec;
            end else begin
              fail_seen_nxt_s = 1'b1;
            end
          end else begin
            mismatch_cnt_nxt_s = mismatch_cnt;
          end

          if (vec == VEC_LAST) begin
            // Last vector of this pair: publish its verdict and move on.
            for (int e = 0; e < N_EXPR; e++) begin
              if (sel == SEL_W'(e)) begin
                equiv_mask_nxt_s[e] = ~pair_bad_s;
              end else begin
                equiv_mask_nxt_s[e] = equiv_mask[e];
              end
            end
            pair_fail_nxt_s = 1'b0;
            vec_nxt_s       = {N_IN{1'b0}};
            if (sel == SEL_LAST) begin
              state_nxt_s = ST_DONE;
              sel_nxt_s   = {SEL_W{1'b0}};
              busy_nxt_s  = 1'b0;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = ST_DRIVE;
              sel_nxt_s   = sel + SEL_W'(1);
            end
          end else begin
            pair_fail_nxt_s = pair_bad_s;
            vec_nxt_s       = vec + N_IN'(1);
            state_nxt_s     = ST_DRIVE;
          end
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
        sel_nxt_s   = {SEL_W{1'b0}};
        vec_nxt_s   = {N_IN{1'b0}};
      end
    endcase
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      pair_fail_r    <= 1'b0;
      sel            <= {SEL_W{1'b0}};
      vec            <= {N_IN{1'b0}};
      busy           <= 1'b0;
      done           <= 1'b0;
      equiv_mask     <= {N_EXPR{1'b0}};
      mismatch_cnt   <= {CNT_W{1'b0}};
      fail_seen      <= 1'b0;
      first_fail_sel <= {SEL_W{1'b0}};
      first_fail_vec <= {N_IN{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      pair_fail_r    <= pair_fail_nxt_s;
      sel            <= sel_nxt_s;
      vec            <= vec_nxt_s;
      busy           <= busy_nxt_s;
      done           <= done_nxt_s;
      equiv_mask     <= equiv_mask_nxt_s;
      mismatch_cnt   <= mismatch_cnt_nxt_s;
      fail_seen      <= fail_seen_nxt_s;
      first_fail_sel <= first_fail_sel_nxt_s;
      first_fail_vec <= first_fail_vec_nxt_s;
    end
  end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_equiv_sweep_ctrl
//
// Self-checking bench for equiv_sweep_ctrl at default parameters. A small
// behavioural bank answers the DUT's sel/vec with s_orig/s_simp; faults and X
// values are injected per (sel, vec) point from the current test record.
// -----------------------------------------------------------------------------
module tb_equiv_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] sel;
  logic [1:0] vec;
  logic       s_orig;
  logic       s_simp;
  logic       busy;
  logic       done;
  logic [4:0] equiv_mask;
  logic [4:0] mismatch_cnt;
  logic       fail_seen;
  logic [2:0] first_fail_sel;
  logic [1:0] first_fail_vec;

  // Point index p = sel*4 + vec; bit p of fault_map inverts s_simp there,
  // bit p of x_map forces s_orig to X there.
  logic [19:0] fault_map;
  logic [19:0] x_map;

  int checks;
  int errors;

  equiv_sweep_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .sel            (sel),
    .vec            (vec),
    .s_orig         (s_orig),
    .s_simp         (s_simp),
    .busy           (busy),
    .done           (done),
    .equiv_mask     (equiv_mask),
    .mismatch_cnt   (mismatch_cnt),
    .fail_seen      (fail_seen),
    .first_fail_sel (first_fail_sel),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expression bank model: the nominal function is the parity of {sel, vec},
  // which is 1 at (4,00) so an X resolved to 0 still differs there.
  always_comb begin
    int  p;
    logic base;
    p    = int'(sel) * 4 + int'(vec);
    base = ^{sel, vec};
    if (p < 20) begin
      s_orig = x_map[p] ? 1'bx : base;
      s_simp = base ^ fault_map[p];
    end else begin
      s_orig = base;
      s_simp = base;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one sweep and follow it to done (bounded). Counts busy cycles and
  // walk errors against the expected (sel, vec) sequence, each point held 2
  // cycles. Extra start pulses are issued while busy; they must be ignored.
  task automatic do_sweep(input bit hold, output int nbusy, output int nwalk,
                          output bit got_done);
    int guard;
    nbusy    = 0;
    nwalk    = 0;
    guard    = 0;
    got_done = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    while (!got_done && guard < 200) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (!busy || sel != 3'((nbusy / 2) / 4) || vec != 2'((nbusy / 2) % 4))
          nwalk++;
        nbusy++;
        start = hold || nbusy == 7 || nbusy == 20;
        @(negedge clk);
        guard++;
      end
    end
    start = hold;
  endtask

  typedef struct {
    string       name;
    logic [19:0] fault;
    logic [19:0] xpt;
    logic [4:0]  exp_mask;
    logic [4:0]  exp_cnt;
    logic        exp_fs;
    logic [2:0]  exp_ffs;
    logic [1:0]  exp_ffv;
  } vec_t;

  vec_t tv[5];

  initial begin
    int nbusy;
    int nwalk;
    bit got_done;

    checks = 0;
    errors = 0;

    tv[0] = '{"clean",    20'h00000, 20'h00000, 5'b11111, 5'd0,  1'b0, 3'd0, 2'd0};
    tv[1] = '{"one_flt",  20'h00800, 20'h00000, 5'b11011, 5'd1,  1'b1, 3'd2, 2'd3};
    tv[2] = '{"multi_x",  20'h01060, 20'h10000, 5'b00101, 5'd4,  1'b1, 3'd1, 2'd1};
    tv[3] = '{"edges",    20'h80001, 20'h00000, 5'b01110, 5'd2,  1'b1, 3'd0, 2'd0};
    tv[4] = '{"all_flt",  20'hFFFFF, 20'h00000, 5'b00000, 5'd20, 1'b1, 3'd0, 2'd0};

    fault_map = 20'h0;
    x_map     = 20'h0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, sel, vec, equiv_mask, mismatch_cnt, fail_seen,
                          first_fail_sel, first_fail_vec}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven full sweeps.
    for (int i = 0; i < 5; i++) begin
      fault_map = tv[i].fault;
      x_map     = tv[i].xpt;
      do_sweep(1'b0, nbusy, nwalk, got_done);
      check({tv[i].name, "_done_seen"}, 32'(got_done), 32'd1);
      check({tv[i].name, "_busy_len"},  32'(nbusy), 32'd40);
      check({tv[i].name, "_walk"},      32'(nwalk), 32'd0);
      check({tv[i].name, "_busy_at_done"}, {busy, sel, vec}, 32'd0);
      check({tv[i].name, "_mask"},      32'(equiv_mask),     32'(tv[i].exp_mask));
      check({tv[i].name, "_cnt"},       32'(mismatch_cnt),   32'(tv[i].exp_cnt));
      check({tv[i].name, "_fail_seen"}, 32'(fail_seen),      32'(tv[i].exp_fs));
      check({tv[i].name, "_ff_sel"},    32'(first_fail_sel), 32'(tv[i].exp_ffs));
      check({tv[i].name, "_ff_vec"},    32'(first_fail_vec), 32'(tv[i].exp_ffv));
      @(negedge clk);
      check({tv[i].name, "_done_pulse"}, {busy, done}, 32'd0);
      check({tv[i].name, "_hold"}, 32'(equiv_mask), 32'(tv[i].exp_mask));
    end

    // Abort in the SAMPLE of (2,01) with a fault there: compare is discarded.
    fault_map = 20'h00200;
    x_map     = 20'h0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 19; k++) @(negedge clk);
    check("abort_pre_point", {busy, sel, vec}, {29'd0, 1'b1, 3'd2, 2'd1});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {busy, done, sel, vec}, 32'd0);
    check("abort_mask", 32'(equiv_mask), 32'(5'b00011));
    check("abort_cnt",  {fail_seen, mismatch_cnt}, 32'd0);
    @(negedge clk);
    check("abort_no_done", {busy, done}, 32'd0);
    fault_map = 20'h0;
    do_sweep(1'b0, nbusy, nwalk, got_done);
    check("after_abort_len",  32'(nbusy), 32'd40);
    check("after_abort_mask", 32'(equiv_mask), 32'(5'b11111));
    @(negedge clk);

    // start held high: back-to-back sweeps with one IDLE cycle between.
    do_sweep(1'b1, nbusy, nwalk, got_done);
    check("hold_len", 32'(nbusy), 32'd40);
    @(negedge clk);
    check("hold_gap_idle", {busy, done}, 32'd0);
    @(negedge clk);
    check("hold_restart", {busy, sel, vec, equiv_mask}, {22'd0, 1'b1, 3'd0, 2'd0, 5'd0});
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_drive", {busy, done}, 32'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("start_abort_idle1", {busy, done}, 32'd0);
    @(negedge clk);
    check("start_abort_idle2", {busy, done}, 32'd0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // Reset at cycle 17 of a sweep with a fault at (0,01).
    fault_map = 20'h00002;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 17; k++) @(negedge clk);
    check("pre_reset_state", {busy, equiv_mask, mismatch_cnt, fail_seen},
          {20'd0, 1'b1, 5'b00010, 5'd1, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset", {busy, done, sel, vec, equiv_mask, mismatch_cnt, fail_seen,
                        first_fail_sel, first_fail_vec}, 32'd0);
    @(negedge clk);
    check("mid_reset_idle", {busy, done}, 32'd0);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset_with_start", {busy, done, sel, vec}, 32'd0);
    @(negedge clk);
    check("reset_with_start_idle", {busy, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
